// File: rtl/sigma_delta_cic_decimator.sv
// 3rd-order CIC (sinc^3) decimator for a 1-bit sigma-delta stream; integrators at bit rate, one
// sequenced comb pass per decimated sample. Optional SD_DECIM_SETTLE_EN hides the first 3 strobes.
module sigma_delta_cic_decimator #(
    parameter int LOG2_DECIM = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_en,
    output logic signed [17:0] sample_out,
    output logic               sample_out_rdy
);

    // Register growth is 3*LOG2_DECIM bits plus sign; derived, so kept local.
    localparam int ACC_W = 2 + 3 * LOG2_DECIM;
    localparam int DECIM = 1 << LOG2_DECIM;
    localparam int SHIFT = 3 * LOG2_DECIM - 17;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-131072);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COMB1 = 3'd1,
        S_COMB2 = 3'd2,
        S_COMB3 = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    function automatic logic signed [17:0] sat18(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[17:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[17:0];
        end else begin
            return v[17:0];
        end
    endfunction

    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] integ1_q, integ1_d;
    logic signed [ACC_W-1:0] integ2_q, integ2_d;
    logic signed [ACC_W-1:0] integ3_q, integ3_d;
    logic signed [ACC_W-1:0] snap_q, snap_d;
    logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
    logic                    tick;

    logic signed [ACC_W-1:0] d1_q, d1_d;
    logic signed [ACC_W-1:0] d2_q, d2_d;
    logic signed [ACC_W-1:0] d3_q, d3_d;
    logic signed [ACC_W-1:0] comb_q, comb_d;
    logic signed [ACC_W-1:0] shifted;
    logic signed [17:0]      sample_q, sample_d;
    logic                    rdy_q, rdy_d;
    logic                    settle_ok;
    state_t                  state_q, state_d;

    // Bit-rate stage: integrator cascade, decimation counter, snapshot on tick
    always_comb begin
        x        = din ? ACC_W'(1) : {ACC_W{1'b1}};
        integ1_d = integ1_q;
        integ2_d = integ2_q;
        integ3_d = integ3_q;
        cnt_d    = cnt_q;
        if (din_en) begin
            integ1_d = integ1_q + x;
            integ2_d = integ2_q + integ1_d;
            integ3_d = integ3_q + integ2_d;
            cnt_d    = cnt_q + LOG2_DECIM'(1);
        end
        tick   = din_en && (cnt_q == LOG2_DECIM'(DECIM - 1));
        snap_d = tick ? integ3_d : snap_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            integ1_q <= '0;
            integ2_q <= '0;
            integ3_q <= '0;
            snap_q   <= '0;
            cnt_q    <= '0;
        end else begin
            integ1_q <= integ1_d;
            integ2_q <= integ2_d;
            integ3_q <= integ3_d;
            snap_q   <= snap_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SD_DECIM_SETTLE_EN
    logic [1:0] settle_q, settle_d;

    always_comb begin
        settle_d = settle_q;
        if (state_q == S_OUT && settle_q != 2'd3) begin
            settle_d = settle_q + 2'd1;
        end
        settle_ok = (settle_q == 2'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_q <= '0;
        end else begin
            settle_q <= settle_d;
        end
    end
`else
    always_comb begin
        settle_ok = 1'b1;
    end
`endif

    // Comb sequencer: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (tick) state_d = S_COMB1;
            S_COMB1: state_d = S_COMB2;
            S_COMB2: state_d = S_COMB3;
            S_COMB3: state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One comb section per state; comb_q carries the running difference forward
    always_comb begin
        comb_d   = comb_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        d3_d     = d3_q;
        sample_d = sample_q;
        rdy_d    = 1'b0;
        shifted  = comb_q >>> SHIFT;
        unique case (state_q)
            S_COMB1: begin
                comb_d = snap_q - d1_q;
                d1_d   = snap_q;
            end
            S_COMB2: begin
                comb_d = comb_q - d2_q;
                d2_d   = comb_q;
            end
            S_COMB3: begin
                comb_d = comb_q - d3_q;
                d3_d   = comb_q;
            end
            S_OUT: begin
                sample_d = sat18(shifted);
                rdy_d    = settle_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comb_q   <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            sample_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            comb_q   <= comb_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            sample_q <= sample_d;
            rdy_q    <= rdy_d;
        end
    end

    assign sample_out     = sample_q;
    assign sample_out_rdy = rdy_q;

endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Bench for sigma_delta_cic_decimator: arithmetic sinc^3 model (exact running sums, third difference
// of snapshots) compared every cycle, plus hand-computed literal expectations per directed run.
module tb_sigma_delta_cic_decimator;

    localparam int L     = 6;
    localparam int ACC_W = 2 + 3 * L;
    localparam int R     = 1 << L;
    localparam int SHIFT = 3 * L - 17;
`ifdef SD_DECIM_SETTLE_EN
    localparam int HIDDEN = 3;
`else
    localparam int HIDDEN = 0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               din = 1'b0;
    logic               din_en = 1'b0;
    logic signed [17:0] sample_out;
    logic               sample_out_rdy;

    sigma_delta_cic_decimator #(.LOG2_DECIM(L)) dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .din_en         (din_en),
        .sample_out     (sample_out),
        .sample_out_rdy (sample_out_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_near(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act >= exp - tol && act <= exp + tol) passes++;
        else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { longint due; longint val; } pend_t;
    pend_t  pend[$];
    longint hist[$];
    longint s1, s2, s3;
    longint cyc = 0;
    int     strobes;
    int     outs;
    logic   exp_rdy = 1'b0;
    longint exp_hold = 0;

    function automatic longint hget(input int i);
        if (i < 0) return 0;
        return hist[i];
    endfunction

    function automatic longint cic_expect();
        int n;
        longint y, v;
        logic signed [ACC_W-1:0] w;
        n = hist.size() - 1;
        y = hget(n) - 3 * hget(n - 1) + 3 * hget(n - 2) - hget(n - 3);
        w = y[ACC_W-1:0];
        v = longint'(w) >>> SHIFT;
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
        return v;
    endfunction

    always @(posedge clk) begin
        longint x;
        cyc++;
        exp_rdy = 1'b0;
        if (reset) begin
            pend.delete();
            hist.delete();
            s1 = 0; s2 = 0; s3 = 0;
            strobes = 0;
            outs = 0;
            exp_hold = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_hold = pend[0].val;
                pend.delete(0);
                exp_rdy = (outs >= HIDDEN);
                if (outs < HIDDEN) outs++;
            end
            if (din_en) begin
                x = din ? 1 : -1;
                s1 += x; s2 += s1; s3 += s2;
                strobes++;
                if (strobes == R) begin
                    strobes = 0;
                    hist.push_back(s3);
                    pend.push_back('{due: cyc + 4, val: cic_expect()});
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    longint rdy_val[$];
    longint rdy_cyc[$];
    logic   prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_rdy", sample_out_rdy, 0);
            chk("reset_sample", sample_out, 0);
        end else begin
            chk("rdy", sample_out_rdy, exp_rdy);
            chk("sample_out", sample_out, exp_hold);
            if (sample_out_rdy) begin
                chk("rdy_single_cycle", prev_rdy, 0);
                rdy_val.push_back(sample_out);
                rdy_cyc.push_back(cyc);
            end
        end
        prev_rdy = sample_out_rdy;
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic en, input logic d);
        din_en = en;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        din_en = 1'b0;
        din    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_val.delete();
        rdy_cyc.delete();
    endtask

    function automatic longint qv(input int i);
        if (i < rdy_val.size()) return rdy_val[i];
        return 64'sd999999999;
    endfunction

    task automatic check_run(input string tag, input int nsamp, input int spacing,
                             input longint settled, input longint tol);
        int first;
        chk({tag, "_rdy_count"}, rdy_val.size(), nsamp - HIDDEN);
        for (int i = 1; i < rdy_cyc.size(); i++)
            chk({tag, "_rdy_spacing"}, rdy_cyc[i] - rdy_cyc[i-1], spacing);
        first = (HIDDEN >= 2) ? 0 : 2 - HIDDEN;
        for (int i = first; i < nsamp - HIDDEN; i++)
            chk_near({tag, "_settled"}, qv(i), settled, tol);
    endtask

    initial begin
        longint rel;
        logic [7:0] pat;
        pat = 8'b1101_1010;

        do_reset();
        chk("post_reset_sample", sample_out, 0);

        // all ones: saturates at +full scale
        repeat (5 * R) step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b0);
        check_run("ones", 5, 64, 131071, 0);
`ifndef SD_DECIM_SETTLE_EN
        chk("ones_first", qv(0), 22880);
        chk("ones_second", qv(1), 110240);
`else
        chk("ones_first_visible", qv(0), 131071);
`endif

        // all zeros: exactly negative full scale, no wrap
        do_reset();
        repeat (5 * R) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        check_run("zeros", 5, 64, -131072, 0);
`ifndef SD_DECIM_SETTLE_EN
        chk("zeros_first", qv(0), -22880);
        chk("zeros_second", qv(1), -110240);
`endif

        // alternating bits, strobe every 3rd clock
        do_reset();
        for (int i = 0; i < 5 * R; i++) begin
            step(1'b1, (i % 2) == 0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end
        repeat (8) step(1'b0, 1'b0);
        check_run("alt", 5, 192, 0, 0);

        // density 5/8 stream, mean +0.25 -> 32768
        do_reset();
        for (int i = 0; i < 6 * R; i++) step(1'b1, pat[i % 8]);
        repeat (8) step(1'b0, 1'b0);
        check_run("dens58", 6, 64, 32768, 256);

        // reset asserted while the sequencer is in COMB2
        do_reset();
        repeat (R) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        reset = 1'b0;
        rel = cyc;
        chk("midreset_no_rdy", rdy_val.size(), 0);
        chk("midreset_sample", sample_out, 0);
        repeat (R) step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b0);
`ifndef SD_DECIM_SETTLE_EN
        chk("midreset_rdy_count", rdy_val.size(), 1);
        chk("midreset_rdy_delay", (rdy_cyc.size() > 0) ? rdy_cyc[0] - rel : -1, R + 4);
        chk("midreset_value", qv(0), 22880);
`else
        chk("midreset_rdy_count", rdy_val.size(), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
